// File: rtl/act_stream_pkg.sv
// Shared element type and fp32 field positions for the activation stream collector.
package act_stream_pkg;

  localparam int ACT_DATA_W   = 32;
  localparam int FP32_EXP_MSB = 30;
  localparam int FP32_EXP_LSB = 23;
  localparam int FP32_MAN_W   = 23;

  typedef struct packed {
    logic                  last;
    logic [ACT_DATA_W-1:0] data;
  } act_elem_t;

  // Exponent all ones with a non-zero mantissa; infinities are excluded.
  function automatic logic fp32_is_nan(input logic [ACT_DATA_W-1:0] value);
    return (&value[FP32_EXP_MSB:FP32_EXP_LSB]) && (|value[FP32_MAN_W-1:0]);
  endfunction

endpackage

// File: rtl/act_sync_fifo.sv
// Single-clock FIFO of act_elem_t with a registered first-word-fall-through head.
// Full/empty come from the level counter; pointers wrap naturally.
module act_sync_fifo
  import act_stream_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  act_elem_t        wr_elem,
  input  logic             out_ready,
  output logic             out_valid,
  output act_elem_t        head,
  output logic [LVL_W-1:0] level
);

  localparam logic [LVL_W-1:0] LVL_ONE = LVL_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  act_elem_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] rd_ptr_nxt;
  logic [LVL_W-1:0] level_after_pop;
  logic [LVL_W-1:0] level_nxt;
  logic             pop;
  act_elem_t        head_nxt;

  // When the FIFO drains to nothing in this cycle, the incoming element bypasses
  // the array so it is visible the very next cycle.
  always_comb begin
    pop             = out_valid && out_ready;
    rd_ptr_nxt      = pop ? rd_ptr + PTR_ONE : rd_ptr;
    level_after_pop = pop ? level - LVL_ONE : level;
    level_nxt       = push ? level_after_pop + LVL_ONE : level_after_pop;
    head_nxt        = (push && (level_after_pop == '0)) ? wr_elem : mem[rd_ptr_nxt];
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_elem;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      out_valid <= 1'b0;
      head      <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      rd_ptr    <= rd_ptr_nxt;
      level     <= level_nxt;
      out_valid <= (level_nxt != '0);
      if (level_nxt != '0) begin
        head <= head_nxt;
      end
    end
  end

endmodule

// File: rtl/act_stream_collector.sv
// Absorbs the no-backpressure activation stream into a FIFO, tags tensor ends and
// re-presents it as ready/valid. Define ACT_STREAM_NANCHK_EN to add NaN monitoring.
module act_stream_collector
  import act_stream_pkg::*;
#(
  parameter  int DATA_W     = ACT_DATA_W,
  parameter  int DEPTH      = 8,
  parameter  int TENSOR_LEN = 16,
  parameter  int AF_THRESH  = 6,
  localparam int LVL_W      = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] input_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              almost_full,
  output logic              overflow,
  output logic [LVL_W-1:0]  level
`ifdef ACT_STREAM_NANCHK_EN
  ,
  output logic              nan_seen,
  output logic [15:0]       nan_count
`endif
);

  localparam int               CNT_W    = (TENSOR_LEN > 1) ? $clog2(TENSOR_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TENSOR_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] LVL_AF   = LVL_W'(AF_THRESH);

  logic             pop;
  logic             push;
  logic             drop;
  logic             is_last;
  logic [CNT_W-1:0] tensor_cnt;
  act_elem_t        wr_elem;
  act_elem_t        head;

  // A full FIFO still accepts when the head leaves in the same cycle.
  always_comb begin
    pop          = out_valid && out_ready;
    push         = valid_in && ((level < LVL_FULL) || pop);
    drop         = valid_in && (level == LVL_FULL) && !pop;
    is_last      = (tensor_cnt == CNT_LAST);
    wr_elem      = '0;
    wr_elem.last = is_last;
    wr_elem.data = input_data;
  end

  assign out_data    = head.data;
  assign out_last    = head.last;
  assign almost_full = (level >= LVL_AF);

  act_sync_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .wr_elem  (wr_elem),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .head     (head),
    .level    (level)
  );

  // Dropped elements never advance the tensor position.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tensor_cnt <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) begin
        tensor_cnt <= is_last ? '0 : tensor_cnt + CNT_ONE;
      end
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

`ifdef ACT_STREAM_NANCHK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nan_seen  <= 1'b0;
      nan_count <= '0;
    end else if (push && fp32_is_nan(input_data)) begin
      nan_seen <= 1'b1;
      if (nan_count != 16'hFFFF) begin
        nan_count <= nan_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_act_stream_collector.sv
// Self-checking bench for act_stream_collector: vector table plus scoreboard queue.
module tb_act_stream_collector;

  localparam int DEPTH = 8;
  localparam int TLEN  = 4;
  localparam int AF    = 6;

  logic        clk        = 1'b0;
  logic        rst_n      = 1'b1;
  logic        valid_in   = 1'b0;
  logic        out_ready  = 1'b0;
  logic [31:0] input_data = '0;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_last;
  logic        almost_full;
  logic        overflow;
  logic [3:0]  level;
`ifdef ACT_STREAM_NANCHK_EN
  logic        nan_seen;
  logic [15:0] nan_count;
`endif

  always #5 clk = ~clk;

  act_stream_collector #(
    .DATA_W(32), .DEPTH(DEPTH), .TENSOR_LEN(TLEN), .AF_THRESH(AF)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid_in   (valid_in),
    .input_data (input_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .almost_full(almost_full),
    .overflow   (overflow),
    .level      (level)
`ifdef ACT_STREAM_NANCHK_EN
    ,
    .nan_seen   (nan_seen),
    .nan_count  (nan_count)
`endif
  );

  typedef struct packed {
    logic        last;
    logic [31:0] data;
  } exp_elem_t;

  typedef struct {
    logic        rst_before;
    logic        vin;
    logic [31:0] din;
    logic        rdy;
    int          exp_level;
    logic        exp_af;
    logic        exp_ovf;
  } vec_t;

  exp_elem_t sb_q[$];
  vec_t      vecs[$];
  int        m_cnt    = 0;
  logic      m_ovf    = 1'b0;
  int        n_checks = 0;
  int        n_fail   = 0;

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    checkValue("out_valid", 32'(out_valid), 32'(sb_q.size() != 0));
    if (sb_q.size() != 0) begin
      checkValue("out_data", out_data, sb_q[0].data);
      checkValue("out_last", 32'(out_last), 32'(sb_q[0].last));
    end
    checkValue("level", 32'(level), 32'(sb_q.size()));
    checkValue("almost_full", 32'(almost_full), 32'(sb_q.size() >= AF));
    checkValue("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  // Called at a falling edge; drives one cycle, updates the model, samples at the next falling edge.
  task automatic applyStimulus(input logic vin, input logic [31:0] din, input logic rdy);
    logic      m_pop;
    logic      m_push;
    exp_elem_t e;
    valid_in   = vin;
    input_data = din;
    out_ready  = rdy;
    m_pop  = (sb_q.size() != 0) && rdy;
    m_push = vin && ((sb_q.size() < DEPTH) || m_pop);
    @(posedge clk);
    if (m_pop) void'(sb_q.pop_front());
    if (m_push) begin
      e.last = (m_cnt == TLEN - 1);
      e.data = din;
      sb_q.push_back(e);
      m_cnt = (m_cnt == TLEN - 1) ? 0 : m_cnt + 1;
    end else if (vin) begin
      m_ovf = 1'b1;
    end
    @(negedge clk);
    checkOutput();
  endtask

  // Asserts reset away from any clock edge and checks outputs clear immediately.
  task automatic doReset();
    #2;
    rst_n     = 1'b0;
    valid_in  = 1'b0;
    out_ready = 1'b0;
    #1;
    sb_q.delete();
    m_cnt = 0;
    m_ovf = 1'b0;
    checkValue("rst_out_valid", 32'(out_valid), 32'd0);
    checkValue("rst_out_data", out_data, 32'd0);
    checkValue("rst_out_last", 32'(out_last), 32'd0);
    checkValue("rst_level", 32'(level), 32'd0);
    checkValue("rst_almost_full", 32'(almost_full), 32'd0);
    checkValue("rst_overflow", 32'(overflow), 32'd0);
`ifdef ACT_STREAM_NANCHK_EN
    checkValue("rst_nan_seen", 32'(nan_seen), 32'd0);
    checkValue("rst_nan_count", 32'(nan_count), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic vec_t mkVec(input logic rb, input logic vin, input logic [31:0] din,
                                 input logic rdy, input int lvl, input logic af, input logic ovf);
    vec_t v;
    v.rst_before = rb;
    v.vin        = vin;
    v.din        = din;
    v.rdy        = rdy;
    v.exp_level  = lvl;
    v.exp_af     = af;
    v.exp_ovf    = ovf;
    return v;
  endfunction

  initial begin
    int          lasts_seen;
    logic [31:0] held;
    logic        stalled;
    logic        rdy_now;

    // Basic stream: each element passes through with one cycle of latency.
    vecs.push_back(mkVec(1'b1, 1'b1, 32'h3F80_0000, 1'b1, 1, 1'b0, 1'b0));
    vecs.push_back(mkVec(1'b0, 1'b1, 32'h4000_0000, 1'b1, 1, 1'b0, 1'b0));
    vecs.push_back(mkVec(1'b0, 1'b1, 32'h4040_0000, 1'b1, 1, 1'b0, 1'b0));
    vecs.push_back(mkVec(1'b0, 1'b0, 32'h0000_0000, 1'b1, 0, 1'b0, 1'b0));
    // Fill with no consumer: level saturates at 8, elements 9 and 10 dropped.
    for (int i = 1; i <= 10; i++) begin
      vecs.push_back(mkVec(i == 1, 1'b1, 32'h1000_0000 + 32'(i), 1'b0,
                           (i > 8) ? 8 : i, i >= 6, i >= 9));
    end
    // Drain, then one extra ready cycle on an empty FIFO.
    for (int i = 1; i <= 9; i++) begin
      vecs.push_back(mkVec(1'b0, 1'b0, 32'h0, 1'b1, (i > 8) ? 0 : 8 - i, (8 - i) >= 6, 1'b1));
    end

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst_before) doReset();
      applyStimulus(vecs[i].vin, vecs[i].din, vecs[i].rdy);
      checkValue("tbl_level", 32'(level), 32'(vecs[i].exp_level));
      checkValue("tbl_almost_full", 32'(almost_full), 32'(vecs[i].exp_af));
      checkValue("tbl_overflow", 32'(overflow), 32'(vecs[i].exp_ovf));
    end

    // Tensor tagging: 9 elements give exactly two lasts, then counter resumes at 1.
    doReset();
    lasts_seen = 0;
    for (int i = 1; i <= 9; i++) begin
      applyStimulus(1'b1, 32'h0000_00A0 + 32'(i), 1'b1);
      if (out_valid && out_last) begin
        lasts_seen++;
        checkValue("last_position", out_data, (i == 4) ? 32'h0000_00A4 : 32'h0000_00A8);
      end
    end
    checkValue("last_count", 32'(lasts_seen), 32'd2);
    applyStimulus(1'b1, 32'h0000_00B0, 1'b1);
    checkValue("no_last_10", 32'(out_last), 32'd0);
    applyStimulus(1'b1, 32'h0000_00B1, 1'b1);
    checkValue("no_last_11", 32'(out_last), 32'd0);
    applyStimulus(1'b1, 32'h0000_00B2, 1'b1);
    checkValue("tensor_wrap", 32'(out_last), 32'd1);
    applyStimulus(1'b0, 32'h0, 1'b1);

    // Full FIFO with simultaneous push and pop: nothing dropped, head advances.
    doReset();
    for (int i = 1; i <= 8; i++) applyStimulus(1'b1, 32'h2000_0000 + 32'(i), 1'b0);
    applyStimulus(1'b1, 32'h2000_0009, 1'b1);
    checkValue("full_pp_level", 32'(level), 32'd8);
    checkValue("full_pp_overflow", 32'(overflow), 32'd0);
    checkValue("full_pp_head", out_data, 32'h2000_0002);
    for (int i = 0; i < 9; i++) applyStimulus(1'b0, 32'h0, 1'b1);

    // Backpressure: ready toggles under a continuous push; head holds while stalled.
    doReset();
    for (int i = 0; i < 12; i++) begin
      rdy_now = 1'(i % 2);
      stalled = out_valid && !rdy_now;
      held    = out_data;
      applyStimulus(1'b1, 32'h3000_0000 + 32'(i), rdy_now);
      if (stalled) checkValue("stall_hold", out_data, held);
    end
    doReset();
    applyStimulus(1'b1, 32'h4000_00C0, 1'b1);
    checkValue("post_reset_valid", 32'(out_valid), 32'd1);
    checkValue("post_reset_last", 32'(out_last), 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b1);

`ifdef ACT_STREAM_NANCHK_EN
    doReset();
    applyStimulus(1'b1, 32'h7FC0_0000, 1'b1);
    applyStimulus(1'b1, 32'h7F80_0000, 1'b1);
    applyStimulus(1'b1, 32'h7F80_0001, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkValue("nan_count", 32'(nan_count), 32'd2);
    checkValue("nan_seen", 32'(nan_seen), 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
